vga_draw_arbiter: RTL
=====================

# vga_draw_arbiter

Single-writer front end for the VGA adapter's pixel write port. It merges three pixel-write sources into one registered write stream: the screen eraser (`erase_*`), and two sprite/obstacle renderers (client 0, client 1) using valid/ready handshakes. The eraser has absolute priority. Client bursts (one sprite) are never interleaved. Off-screen pixels are dropped and counted.

## Interface
- `XSCREEN`, 640, horizontal resolution; accepted x must be `< XSCREEN`.
- `YSCREEN`, 480, vertical resolution; accepted y must be `< YSCREEN`.
- `Clock`  in  1  system clock, all logic on rising edge.
- `Resetn`  in  1  reset, synchronous, active-low.
- `erase_active`  in  1  eraser owns the port while high; cannot be stalled.
- `erase_x` / `erase_y` / `erase_color`  in  10/9/9  eraser pixel.
- `erase_write`  in  1  eraser pixel valid (qualified by `erase_active`).
- `c0_valid`, `c1_valid`  in  1  client pixel offered.
- `c0_x`, `c1_x`  in  10  client x.
- `c0_y`, `c1_y`  in  9  client y.
- `c0_color`, `c1_color`  in  9  client colour.
- `c0_last`, `c1_last`  in  1  pixel is final of its burst.
- `c0_ready`, `c1_ready`  out  1  pixel accepted this cycle when valid&&ready.
- `VGA_X`  out  10  registered write x.
- `VGA_Y`  out  9  registered write y.
- `VGA_COLOR`  out  9  registered write colour.
- `VGA_WRITE`  out  1  registered write strobe.
- `drop_count`  out  16  saturating count of accepted-but-off-screen pixels.
- `busy`  out  1  `state != IDLE || erase_active`.

## Operation
- States: IDLE, HOLD0, HOLD1. Round-robin pointer `rr` (0/1).
- Eraser override: `erase_active` high forces both readies to 0 in every state. The state is left unchanged, so a suspended burst resumes when `erase_active` falls.
- Eraser writes:
  - `erase_active && erase_write` drives a write of the erase pixel.
  - `erase_active && !erase_write` produces no write and no drop.
- IDLE, `erase_active` low: grant goes to the sole valid client. If both are valid, grant goes to client `rr`.
  - `cN_ready` is combinational on the valid inputs in IDLE only. The granted pixel is accepted in the same cycle.
  - Accepted pixel with `last=0` moves to HOLDn.
  - Accepted pixel with `last=1` stays in IDLE and sets `rr` to the other client.
- HOLDn: `cN_ready = !erase_active`; the other client's ready is 0.
  - Accepted pixel with `last=1` moves to IDLE and sets `rr` to the other client.
  - Valid low in HOLDn keeps the grant; the burst may have gaps.
- Bounds check on any pixel to be written (eraser or client): `x < XSCREEN && y < YSCREEN`.
  - In bounds: write.
  - Out of bounds: no write; `drop_count` increments, saturating at 16'hFFFF.
  - An out-of-bounds pixel with `last=1` still ends the burst.
- Write-data hold: when no write occurs, `VGA_X/Y/COLOR` hold their previous values and `VGA_WRITE` is 0.
- Reset values:
  - State IDLE, `rr=0`.
  - `VGA_X`, `VGA_Y`, `VGA_COLOR`, `VGA_WRITE`, `drop_count` all 0.
  - `busy` follows its equation (0 unless `erase_active`).
  - Readies follow their equations; they are 0 while `Resetn` is low.

## Timing
- Latency: pixel accepted (or eraser pixel presented) in cycle N appears on `VGA_*` with `VGA_WRITE=1` in cycle N+1. Exactly one write per accepted in-bounds pixel.
- Throughput: one pixel per cycle, with no bubbles between back-to-back bursts from different clients.
- `erase_active` rising in cycle N:
  - Client readies are 0 in cycle N.
  - A client pixel accepted in N-1 is still written in N.
- `erase_active` falling in cycle N: the held client's ready may be 1 in cycle N.
- Reset mid-burst: IDLE from the next cycle; any in-flight output write is cancelled (`VGA_WRITE=0`).
- `drop_count` updates in cycle N+1, aligned with the suppressed write.

## Test plan
- Hold `Resetn=0` 3 cycles, then release with no traffic → all outputs 0, `busy=0`, readies 0.
- c0 offers (10,20,9'h1FF,last=1) alone → `c0_ready=1` same cycle. Next cycle `VGA_X=10`, `VGA_Y=20`, `VGA_COLOR=1FF`, `VGA_WRITE=1` for exactly one cycle.
- c0 and c1 both valid, c0 burst of 3 (last on 3rd) → c0 writes in cycles 1-3 and c1 is granted in cycle 4. On the next simultaneous request c1 waits (rr=0) and c0 is served first.
- `erase_active` rises after 2 of 5 c1 pixels, eraser streams 4 pixels, then falls with c0 valid → the 4 erase writes appear, then the remaining 3 c1 pixels, then c0. No c0 pixel is interleaved.
- c1 offers (640,0) then (0,480), both last=1 → both accepted, `VGA_WRITE` stays 0, `drop_count` = 1 then 2. Forcing 65537 drops leaves `drop_count` at 16'hFFFF.
- `Resetn` pulsed low in HOLD0 mid-burst → next cycle `VGA_WRITE=0` and state IDLE. The subsequent contended request goes to c0 (rr=0).

Source files
------------

// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter: merges the eraser and two burst clients into one registered VGA write port.
// The eraser preempts without changing burst state; off-screen pixels are dropped and counted.
module vga_draw_arbiter #(
    parameter int XSCREEN = 640,
    parameter int YSCREEN = 480
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       erase_active,
    input  logic [9:0] erase_x,
    input  logic [8:0] erase_y,
    input  logic [8:0] erase_color,
    input  logic       erase_write,
    input  logic       c0_valid,
    input  logic [9:0] c0_x,
    input  logic [8:0] c0_y,
    input  logic [8:0] c0_color,
    input  logic       c0_last,
    output logic       c0_ready,
    input  logic       c1_valid,
    input  logic [9:0] c1_x,
    input  logic [8:0] c1_y,
    input  logic [8:0] c1_color,
    input  logic       c1_last,
    output logic       c1_ready,
    output logic [9:0] VGA_X,
    output logic [8:0] VGA_Y,
    output logic [8:0] VGA_COLOR,
    output logic       VGA_WRITE,
    output logic [15:0] drop_count,
    output logic       busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] HOLD0 = 2'd1;
    localparam logic [1:0] HOLD1 = 2'd2;
    localparam logic [9:0] XMAX = 10'(XSCREEN);
    localparam logic [8:0] YMAX = 9'(YSCREEN);

    logic [1:0] r_state;
    logic       r_rr;
    logic       w_idle_g0, w_idle_g1, w_acc0, w_acc1, w_pv, w_inb;
    logic [9:0] w_px;
    logic [8:0] w_py, w_pc;

    // rr only breaks ties when both clients request in IDLE
    assign w_idle_g0 = c0_valid && (!c1_valid || !r_rr);
    assign w_idle_g1 = c1_valid && (!c0_valid || r_rr);
    assign c0_ready  = Resetn && !erase_active && (r_state == HOLD0 || (r_state == IDLE && w_idle_g0));
    assign c1_ready  = Resetn && !erase_active && (r_state == HOLD1 || (r_state == IDLE && w_idle_g1));
    assign w_acc0    = c0_valid && c0_ready;
    assign w_acc1    = c1_valid && c1_ready;
    assign w_px      = erase_active ? erase_x : w_acc1 ? c1_x : c0_x;
    assign w_py      = erase_active ? erase_y : w_acc1 ? c1_y : c0_y;
    assign w_pc      = erase_active ? erase_color : w_acc1 ? c1_color : c0_color;
    assign w_pv      = erase_active ? erase_write : (w_acc0 || w_acc1);
    assign w_inb     = w_px < XMAX && w_py < YMAX;
    assign busy      = r_state != IDLE || erase_active;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state    <= IDLE;
            r_rr       <= 1'b0;
            VGA_X      <= '0;
            VGA_Y      <= '0;
            VGA_COLOR  <= '0;
            VGA_WRITE  <= 1'b0;
            drop_count <= '0;
        end else begin
            VGA_WRITE <= w_pv && w_inb;
            if (w_pv && w_inb) begin
                VGA_X     <= w_px;
                VGA_Y     <= w_py;
                VGA_COLOR <= w_pc;
            end
            if (w_pv && !w_inb && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
            if (w_acc0) begin
                r_state <= c0_last ? IDLE : HOLD0;
                if (c0_last) r_rr <= 1'b1;
            end
            if (w_acc1) begin
                r_state <= c1_last ? IDLE : HOLD1;
                if (c1_last) r_rr <= 1'b0;
            end
        end
    end
endmodule
